phase_seq_scheduler: RTL and testbench

- Shares a three-phase cyclic state sequencer (S0 -> S1 -> S2) among NUM_REQ requesters.
- Grants one requester at a time using a round-robin arbiter.
- Steps the granted requester through S0, S1 and S2, holding each phase for a per-phase dwell count, then signals completion.
- Sits between the requesting blocks and the sequenced datapath; phase/phase_valid drive the datapath's state selection.

---
 rtl/phase_seq_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_phase_seq_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_seq_scheduler.sv
// phase_seq_scheduler
//   Shares one three-phase sequencer (S0 -> S1 -> S2) among NUM_REQ
//   requesters. An idle scheduler grants one requester through a
//   round-robin arbiter. It then steps that requester through S0, S1 and
//   S2, holding each phase for its dwell count, and pulses done at the end.
//
// Optional feature: define PHASE_SEQ_DWELL_PROG_EN to make the three dwell
//   registers writable through cfg_we/cfg_sel/cfg_data. Without the macro
//   the cfg_* ports are present but ignored, and the dwell values come from
//   the DWELL0..2 parameters.
//
// Ports
//   clk          clock, all logic on posedge
//   reset        synchronous active-low reset
//   req          per-requester level request, sampled only in IDLE
//   abort        terminate the sequence in progress (PH0..PH2 only)
//   cfg_we       dwell register write strobe
//   cfg_sel      dwell select: 0..2 = S0..S2, 3 ignored
//   cfg_data     dwell value
//   grant        one-hot grant, registered
//   busy         high from grant through DONE
//   phase        current phase; holds its last value while phase_valid = 0
//   phase_valid  high in PH0..PH2
//   done         one-cycle completion pulse
//   done_id      completed requester index, valid with done
//   aborted      one-cycle pulse following an abort
module phase_seq_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8,
    parameter int DWELL0  = 4,
    parameter int DWELL1  = 2,
    parameter int DWELL2  = 3,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               abort,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [CNT_W-1:0]   cfg_data,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic [1:0]         phase,
    output logic               phase_valid,
    output logic               done,
    output logic [ID_W-1:0]    done_id,
    output logic               aborted
);

    typedef enum logic [2:0] {IDLE, PH0, PH1, PH2, DONE} state_t;

    state_t                    state, state_nxt;
    logic [ID_W-1:0]           rr_ptr, cur_id, win_id;
    logic                      win_vld;
    logic [CNT_W-1:0]          cnt;
    logic [2:0][CNT_W-1:0]     dwell;
    logic                      in_phase, last_cyc;
    int                        arb_idx;

    assign in_phase = (state == PH0) || (state == PH1) || (state == PH2);
    assign last_cyc = (cnt == '0);

    // The counter is loaded with dwell-1 and the phase ends when it reaches 0.
    // This makes a dwell of 0 behave like a dwell of 1.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    // ---------------- dwell registers ----------------
`ifdef PHASE_SEQ_DWELL_PROG_EN
    // A write lands in the register only. The running counter does not see
    // it until the next entry into that phase.
    always_ff @(posedge clk) begin
        if (!reset)
            dwell <= {CNT_W'(DWELL2), CNT_W'(DWELL1), CNT_W'(DWELL0)};
        else if (cfg_we && (cfg_sel != 2'd3))
            dwell[cfg_sel] <= cfg_data;
    end
`else
    logic unused_cfg;
    assign dwell      = {CNT_W'(DWELL2), CNT_W'(DWELL1), CNT_W'(DWELL0)};
    assign unused_cfg = ^{cfg_we, cfg_sel, cfg_data};
`endif

    // ---------------- round-robin arbiter ----------------
    // The scan runs from the farthest offset back to offset 0. The last
    // match written is therefore the first set bit at or above rr_ptr,
    // with wrap-around.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        arb_idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            arb_idx = int'(rr_ptr) + i;
            if (arb_idx >= NUM_REQ)
                arb_idx = arb_idx - NUM_REQ;
            if (req[ID_W'(arb_idx)]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(arb_idx);
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (win_vld) state_nxt = PH0;
            PH0:  if (abort) state_nxt = IDLE; else if (last_cyc) state_nxt = PH1;
            PH1:  if (abort) state_nxt = IDLE; else if (last_cyc) state_nxt = PH2;
            PH2:  if (abort) state_nxt = IDLE; else if (last_cyc) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs decoded from state ----------------
    always_comb begin
        busy        = (state != IDLE);
        phase_valid = in_phase;
        done        = (state == DONE);
        done_id     = cur_id;
    end

    // ---------------- datapath registers ----------------
    // These registers follow the same decisions as the next-state logic.
    // grant is held here so that it stays a clean registered output.
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant   <= '0;
            cur_id  <= '0;
            rr_ptr  <= '0;
            cnt     <= '0;
            phase   <= 2'd0;
            aborted <= 1'b0;
        end else begin
            aborted <= 1'b0;
            if (state == IDLE) begin
                if (win_vld) begin
                    grant  <= NUM_REQ'(1) << win_id;
                    cur_id <= win_id;
                    rr_ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
                    cnt    <= load_val(dwell[0]);
                    phase  <= 2'd0;
                end
            end else if (in_phase) begin
                if (abort) begin
                    // Abort wins over the PH2 -> DONE step. rr_ptr keeps its
                    // advanced value.
                    grant   <= '0;
                    aborted <= 1'b1;
                end else if (last_cyc) begin
                    case (state)
                        PH0: begin
                            phase <= 2'd1;
                            cnt   <= load_val(dwell[1]);
                        end
                        PH1: begin
                            phase <= 2'd2;
                            cnt   <= load_val(dwell[2]);
                        end
                        default: grant <= '0;   // PH2 -> DONE
                    endcase
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

    // ---------------- invariants ----------------
    a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));
    a_done_no_grant: assert property (@(posedge clk) disable iff (!reset) done |-> (grant == '0));
    a_valid_busy: assert property (@(posedge clk) disable iff (!reset) phase_valid |-> busy);

endmodule

// File: tb/tb_phase_seq_scheduler.sv
// Self-checking bench for phase_seq_scheduler (NUM_REQ=4, dwells 4/2/3).
// A table of round-robin vectors is followed by hand-written sequences for
// timing, abort, dwell programming and mid-sequence reset. The expected
// done_id values go into a queue and are popped when done pulses.
module tb_phase_seq_scheduler;
    localparam int N   = 4;
    localparam int CW  = 8;
    localparam int LAT = 4 + 2 + 3;   // grant cycle to done cycle
`ifdef PHASE_SEQ_DWELL_PROG_EN
    localparam bit PROG = 1'b1;
`else
    localparam bit PROG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req = '0;
    logic          abort = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_sel = '0;
    logic [CW-1:0] cfg_data = '0;
    logic [N-1:0]  grant;
    logic          busy, phase_valid, done, aborted;
    logic [1:0]    phase;
    logic [1:0]    done_id;

    phase_seq_scheduler #(.NUM_REQ(N), .CNT_W(CW), .DWELL0(4), .DWELL1(2), .DWELL2(3)) dut (
        .clk(clk), .reset(reset), .req(req), .abort(abort),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .grant(grant), .busy(busy), .phase(phase), .phase_valid(phase_valid),
        .done(done), .done_id(done_id), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] exp_grant;
        int           exp_id;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected: got done_id %0d expected no done", done_id);
            end else begin
                chk("done_id", int'(done_id), exp_q.pop_front());
            end
        end
    end

    task automatic wait_grant(input string nm, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: got no grant expected grant within 40 cycles", nm);
        end
    endtask

    task automatic wait_done(input string nm, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        chk(nm, n, LAT);
    endtask

    // Runs one sequence and measures the length of each phase. A dwell
    // write can be issued during PH0 cycle number wr_cyc (0 = no write).
    task automatic run_seq(input logic [N-1:0] r, input logic [N-1:0] eg, input int id,
                           input int wr_cyc, input logic [1:0] ws, input logic [CW-1:0] wd,
                           output int l0, output int l1, output int l2);
        logic ok;
        l0 = 0; l1 = 0; l2 = 0;
        req = r;
        wait_grant("seq_grant_wait", ok);
        req = '0;
        if (!ok) return;
        chk("seq_grant", int'(grant), int'(eg));
        exp_q.push_back(id);
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk);
            cfg_we = 1'b0;
            if (done) break;
            if (phase_valid) begin
                case (phase)
                    2'd0: begin
                        l0++;
                        if (l0 == wr_cyc) begin
                            cfg_we = 1'b1; cfg_sel = ws; cfg_data = wd;
                        end
                    end
                    2'd1: l1++;
                    default: l2++;
                endcase
            end
        end
        chk("seq_done_seen", int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        int n, l0, l1, l2;

        tbl[0] = '{4'b1111, 4'b0010, 1};
        tbl[1] = '{4'b1111, 4'b0100, 2};
        tbl[2] = '{4'b1111, 4'b1000, 3};
        tbl[3] = '{4'b1111, 4'b0001, 0};
        tbl[4] = '{4'b1111, 4'b0010, 1};
        tbl[5] = '{4'b1010, 4'b1000, 3};
        tbl[6] = '{4'b1010, 4'b0010, 1};
        tbl[7] = '{4'b0001, 4'b0001, 0};
        tbl[8] = '{4'b1100, 4'b0100, 2};
        tbl[9] = '{4'b0110, 4'b0010, 1};

        // Reset held with every request set.
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_grant", int'(grant), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_pv", int'(phase_valid), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_aborted", int'(aborted), 0);
            chk("rst_phase", int'(phase), 0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("first_grant", int'(grant), 1);
        exp_q.push_back(0);
        wait_done("first_latency", n);

        // Round-robin table.
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            wait_grant("rr_grant_wait", ok);
            if (ok) begin
                chk($sformatf("rr_grant[%0d]", i), int'(grant), int'(tbl[i].exp_grant));
                exp_q.push_back(tbl[i].exp_id);
                wait_done($sformatf("rr_latency[%0d]", i), n);
            end
        end

        // Single request with detailed phase timing; req dropped after grant.
        req = 4'b0100;
        wait_grant("single_wait", ok);
        req = '0;
        chk("single_grant", int'(grant), 4);
        exp_q.push_back(2);
        for (int off = 0; off <= 10; off++) begin
            if (off > 0) @(negedge clk);
            if (off < 9) begin
                chk($sformatf("single_phase@%0d", off), int'(phase), (off < 4) ? 0 : (off < 6) ? 1 : 2);
                chk($sformatf("single_pv@%0d", off), int'(phase_valid), 1);
                chk($sformatf("single_grant@%0d", off), int'(grant), 4);
            end else if (off == 9) begin
                chk("single_done", int'(done), 1);
                chk("single_done_grant", int'(grant), 0);
                chk("single_done_busy", int'(busy), 1);
                chk("single_done_pv", int'(phase_valid), 0);
            end else begin
                chk("single_idle_busy", int'(busy), 0);
                chk("single_idle_done", int'(done), 0);
            end
        end

        // Abort during the second PH1 cycle of requester 0 (rr_ptr is 3).
        req = 4'b0011;
        wait_grant("abort_wait", ok);
        chk("abort_grant0", int'(grant), 1);
        repeat (5) @(negedge clk);
        chk("abort_at_ph1", int'(phase), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_pulse", int'(aborted), 1);
        chk("abort_grant", int'(grant), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_pv", int'(phase_valid), 0);
        chk("abort_phase_hold", int'(phase), 1);
        @(negedge clk);
        chk("abort_aborted_1cyc", int'(aborted), 0);
        chk("abort_next_grant", int'(grant), 2);
        exp_q.push_back(1);
        req = '0;
        wait_done("abort_next_latency", n);
        abort = 1'b1;                      // abort while in DONE
        @(negedge clk);
        chk("abort_in_done_ignored", int'(aborted), 0);
        @(negedge clk);
        abort = 1'b0;                      // abort issued while IDLE
        chk("abort_in_idle_ignored", int'(aborted), 0);

        // Abort on the final PH2 cycle wins over DONE (rr_ptr 2 -> grant 0).
        req = 4'b0001;
        wait_grant("abort_last_wait", ok);
        req = '0;
        chk("abort_last_grant", int'(grant), 1);
        repeat (8) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_last_pulse", int'(aborted), 1);
        chk("abort_last_nodone", int'(done), 0);
        @(negedge clk);
        chk("abort_last_idle_busy", int'(busy), 0);

        // Dwell programming (rr_ptr is 1). A write to sel 3 must be ignored.
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 8'd0;
        @(negedge clk);
        cfg_sel = 2'd3; cfg_data = 8'd0;
        @(negedge clk);
        cfg_we = 1'b0;
        run_seq(4'b0100, 4'b0100, 2, 2, 2'd0, 8'd7, l0, l1, l2);
        chk("prog_a_ph0", l0, 4);
        chk("prog_a_ph1", l1, PROG ? 1 : 2);
        chk("prog_a_ph2", l2, 3);
        run_seq(4'b1000, 4'b1000, 3, 0, 2'd0, 8'd0, l0, l1, l2);
        chk("prog_b_ph0", l0, PROG ? 7 : 4);
        chk("prog_b_ph1", l1, PROG ? 1 : 2);
        chk("prog_b_ph2", l2, 3);

        // Reset during PH2 (rr_ptr is 0, so this grants requester 1).
        @(negedge clk);
        req = 4'b0010;
        wait_grant("rstmid_wait", ok);
        req = '0;
        chk("rstmid_grant", int'(grant), 2);
        for (int i = 0; i < 40; i++) begin
            if (phase_valid && phase == 2'd2) break;
            @(negedge clk);
        end
        chk("rstmid_in_ph2", int'(phase), 2);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_grant0", int'(grant), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_pv", int'(phase_valid), 0);
        chk("rstmid_done", int'(done), 0);
        chk("rstmid_aborted", int'(aborted), 0);
        chk("rstmid_phase", int'(phase), 0);
        chk("rstmid_done_id", int'(done_id), 0);
        reset = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        chk("rstmid_rr_ptr0", int'(grant), 1);
        req = '0;
        exp_q.push_back(0);
        wait_done("rstmid_latency", n);
        run_seq(4'b0100, 4'b0100, 2, 0, 2'd0, 8'd0, l0, l1, l2);
        chk("rstmid_dwell0", l0, 4);
        chk("rstmid_dwell1", l1, 2);
        chk("rstmid_dwell2", l2, 3);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
